// File: rtl/tqvp_stevej_wdt_pkg.sv
// rtl/tqvp_stevej_wdt_pkg.sv - shared types and default widths for the watchdog reset sequencer
package tqvp_stevej_wdt_pkg;

  // Default counter widths
  localparam int GRACE_W_DEF = 16;
  localparam int PULSE_W_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  // Sequencer states; the encoding is visible on the state output
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARN    = 2'd1,
    ST_RESET   = 2'd2,
    ST_HOLDOFF = 2'd3
  } wdt_state_t;

endpackage

// File: rtl/tqvp_stevej_wdt_downcnt.sv
// rtl/tqvp_stevej_wdt_downcnt.sv - loadable down-counter with zero flag
module tqvp_stevej_wdt_downcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority over decrement; decrement stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tqvp_stevej_wdt_reset_seq.sv
// rtl/tqvp_stevej_wdt_reset_seq.sv - staged warning/reset response to a watchdog expiry
module tqvp_stevej_wdt_reset_seq
  import tqvp_stevej_wdt_pkg::*;
#(
  parameter int GRACE_W = GRACE_W_DEF,
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               expired,
  input  logic               pat,
  input  logic               irq_ack,
  input  logic [GRACE_W-1:0] grace_cycles,
  input  logic [PULSE_W-1:0] pulse_cycles,
  output logic               irq,
  output logic               sys_reset_n,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   reset_count
);

  wdt_state_t         cur_state;
  logic               expired_q;
  logic               rise;
  logic               warn_abort;
  logic               grace_load;
  logic               grace_dec;
  logic               grace_zero;
  logic               pulse_load;
  logic               pulse_dec;
  logic               pulse_zero;
  logic [GRACE_W-1:0] grace_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [PULSE_W-1:0] pulse_load_val;

  // Remember last cycle's expiry level so only a fresh rising edge can start a sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired_q <= 1'b0;
    end else begin
      expired_q <= expired;
    end
  end

  assign rise       = expired & ~expired_q;
  assign warn_abort = pat | ~enable;

  // A zero pulse length still produces a one-cycle pulse
  assign pulse_load_val = (pulse_cycles == '0) ? '0 : (pulse_cycles - PULSE_W'(1));

  assign grace_load = (cur_state == ST_IDLE) & enable & rise;
  assign grace_dec  = (cur_state == ST_WARN) & ~warn_abort & ~grace_zero;
  assign pulse_load = (cur_state == ST_WARN) & ~warn_abort & grace_zero;
  assign pulse_dec  = (cur_state == ST_RESET) & ~pulse_zero;

  tqvp_stevej_wdt_downcnt #(.W(GRACE_W)) u_grace_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grace_load),
    .load_val (grace_cycles),
    .dec      (grace_dec),
    .count    (grace_cnt),
    .zero     (grace_zero)
  );

  tqvp_stevej_wdt_downcnt #(.W(PULSE_W)) u_pulse_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pulse_load),
    .load_val (pulse_load_val),
    .dec      (pulse_dec),
    .count    (pulse_cnt),
    .zero     (pulse_zero)
  );

  // Sequencer FSM with registered irq, reset pulse and saturating event count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= ST_IDLE;
      irq         <= 1'b0;
      sys_reset_n <= 1'b1;
      reset_count <= '0;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (enable && rise) begin
            cur_state <= ST_WARN;
            irq       <= 1'b1;
          end
        end
        ST_WARN: begin
          if (warn_abort) begin
            cur_state <= ST_IDLE;
            irq       <= 1'b0;
          end else if (grace_zero) begin
            cur_state   <= ST_RESET;
            sys_reset_n <= 1'b0;
            if (reset_count != '1) begin
              reset_count <= reset_count + CNT_W'(1);
            end
            if (irq_ack) begin
              irq <= 1'b0;
            end
          end else if (irq_ack) begin
            irq <= 1'b0;
          end
        end
        ST_RESET: begin
          if (pulse_zero) begin
            cur_state   <= ST_HOLDOFF;
            sys_reset_n <= 1'b1;
            irq         <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          if (!expired) begin
            cur_state <= ST_IDLE;
          end
        end
        default: begin
          cur_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign state = cur_state;

  // Counter values are only consumed through their zero flags
  logic unused_cnt;
  assign unused_cnt = ^{grace_cnt, pulse_cnt};

endmodule

// File: tb/tb_tqvp_stevej_wdt_reset_seq.sv
// tb/tb_tqvp_stevej_wdt_reset_seq.sv - directed self-checking bench for the reset sequencer
module tb_tqvp_stevej_wdt_reset_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        expired;
  logic        pat;
  logic        irq_ack;
  logic [15:0] grace_cycles;
  logic [7:0]  pulse_cycles;
  logic        irq;
  logic        sys_reset_n;
  logic [1:0]  state;
  logic [7:0]  reset_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  tqvp_stevej_wdt_reset_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .expired      (expired),
    .pat          (pat),
    .irq_ack      (irq_ack),
    .grace_cycles (grace_cycles),
    .pulse_cycles (pulse_cycles),
    .irq          (irq),
    .sys_reset_n  (sys_reset_n),
    .state        (state),
    .reset_count  (reset_count)
  );

  typedef struct {
    logic        en;
    logic        exp;
    logic        pt;
    logic [15:0] g;
    logic [7:0]  p;
    logic        chk_irq;
    logic        e_irq;
    logic        e_srn;
    logic [1:0]  e_state;
    int          e_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic exp, input logic pt,
                              input logic [15:0] g, input logic [7:0] p,
                              input logic ci, input logic ei, input logic es,
                              input logic [1:0] st, input int c);
    vec_t v;
    v.en = en; v.exp = exp; v.pt = pt; v.g = g; v.p = p;
    v.chk_irq = ci; v.e_irq = ei; v.e_srn = es; v.e_state = st; v.e_cnt = c;
    return v;
  endfunction

  // One full expiry episode; returns cycles spent in WARN and cycles of low reset pulse
  task automatic episode(input logic [15:0] g, input logic [7:0] p,
                         output int warn_n, output int low_n);
    grace_cycles = g;
    pulse_cycles = p;
    enable = 1'b1;
    expired = 1'b1;
    step();
    warn_n = 0;
    low_n = 0;
    while (state == 2'd1 && warn_n < 1000) begin
      warn_n++;
      step();
    end
    while (sys_reset_n == 1'b0 && low_n < 1000) begin
      low_n++;
      step();
    end
    if (exp_count < 255) exp_count++;
    expired = 1'b0;
    step();
    step();
  endtask

  initial begin
    int wn;
    int ln;

    // Escalation: grace 4, pulse 3
    vecs[0]  = mk(1, 1, 0, 4, 3, 1, 1, 1, 2'd1, 0);
    vecs[1]  = mk(1, 1, 0, 4, 3, 1, 1, 1, 2'd1, 0);
    vecs[2]  = mk(1, 1, 0, 4, 3, 1, 1, 1, 2'd1, 0);
    vecs[3]  = mk(1, 1, 0, 4, 3, 1, 1, 1, 2'd1, 0);
    vecs[4]  = mk(1, 1, 0, 4, 3, 1, 1, 1, 2'd1, 0);
    vecs[5]  = mk(1, 1, 0, 4, 3, 0, 0, 0, 2'd2, 1);
    vecs[6]  = mk(1, 1, 0, 4, 3, 0, 0, 0, 2'd2, 1);
    vecs[7]  = mk(1, 1, 0, 4, 3, 0, 0, 0, 2'd2, 1);
    vecs[8]  = mk(1, 1, 0, 4, 3, 1, 0, 1, 2'd3, 1);
    vecs[9]  = mk(1, 1, 0, 4, 3, 1, 0, 1, 2'd3, 1);
    vecs[10] = mk(1, 0, 0, 4, 3, 1, 0, 1, 2'd0, 1);
    vecs[11] = mk(1, 0, 0, 4, 3, 1, 0, 1, 2'd0, 1);
    // Pat rescue on third WARN cycle: grace 10
    vecs[12] = mk(1, 1, 0, 10, 3, 1, 1, 1, 2'd1, 1);
    vecs[13] = mk(1, 1, 0, 10, 3, 1, 1, 1, 2'd1, 1);
    vecs[14] = mk(1, 1, 0, 10, 3, 1, 1, 1, 2'd1, 1);
    vecs[15] = mk(1, 1, 1, 10, 3, 1, 0, 1, 2'd0, 1);
    vecs[16] = mk(1, 1, 0, 10, 3, 1, 0, 1, 2'd0, 1);
    vecs[17] = mk(1, 0, 0, 10, 3, 1, 0, 1, 2'd0, 1);

    rst_n = 1'b0;
    enable = 1'b0;
    expired = 1'b0;
    pat = 1'b0;
    irq_ack = 1'b0;
    grace_cycles = 16'd0;
    pulse_cycles = 8'd0;
    repeat (3) step();
    check("rst_irq", irq, 0);
    check("rst_srn", sys_reset_n, 1);
    check("rst_state", state, 0);
    check("rst_count", reset_count, 0);
    rst_n = 1'b1;
    step();
    check("idle_state", state, 0);
    check("idle_srn", sys_reset_n, 1);

    for (int i = 0; i < 18; i++) begin
      enable = vecs[i].en;
      expired = vecs[i].exp;
      pat = vecs[i].pt;
      grace_cycles = vecs[i].g;
      pulse_cycles = vecs[i].p;
      step();
      check($sformatf("vec%0d_state", i), state, vecs[i].e_state);
      check($sformatf("vec%0d_srn", i), sys_reset_n, vecs[i].e_srn);
      check($sformatf("vec%0d_count", i), reset_count, vecs[i].e_cnt);
      if (vecs[i].chk_irq) check($sformatf("vec%0d_irq", i), irq, vecs[i].e_irq);
    end
    pat = 1'b0;
    exp_count = 1;

    // pulse_cycles=0 gives a one-cycle pulse
    episode(16'd2, 8'd0, wn, ln);
    check("p0_warn_len", wn, 3);
    check("p0_low_len", ln, 1);
    check("p0_count", reset_count, exp_count);
    check("p0_idle", state, 0);

    // grace_cycles=0 gives a one-cycle WARN
    episode(16'd0, 8'd5, wn, ln);
    check("g0_warn_len", wn, 1);
    check("g0_low_len", ln, 5);

    // Pat on the grace==0 cycle wins
    grace_cycles = 16'd2;
    expired = 1'b1;
    step();
    step();
    step();
    pat = 1'b1;
    step();
    pat = 1'b0;
    check("patzero_state", state, 0);
    check("patzero_srn", sys_reset_n, 1);
    step();
    check("patzero_stay", state, 0);
    check("patzero_count", reset_count, exp_count);
    expired = 1'b0;
    step();

    // Rise while disabled is ignored, even once enable returns
    enable = 1'b0;
    expired = 1'b1;
    step();
    check("dis_rise_state", state, 0);
    enable = 1'b1;
    repeat (3) step();
    check("dis_late_state", state, 0);
    check("dis_late_irq", irq, 0);
    expired = 1'b0;
    step();

    // Enable dropped mid-WARN aborts
    grace_cycles = 16'd10;
    expired = 1'b1;
    step();
    step();
    enable = 1'b0;
    step();
    check("endrop_state", state, 0);
    check("endrop_irq", irq, 0);
    enable = 1'b1;
    expired = 1'b0;
    step();

    // irq_ack clears irq but reset still fires on schedule
    grace_cycles = 16'd4;
    pulse_cycles = 8'd2;
    expired = 1'b1;
    step();
    step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("ack_irq", irq, 0);
    check("ack_state", state, 1);
    step();
    check("ack_irq_stays", irq, 0);
    step();
    check("ack_still_warn", state, 1);
    step();
    if (exp_count < 255) exp_count++;
    check("ack_reset_state", state, 2);
    check("ack_reset_srn", sys_reset_n, 0);
    check("ack_count", reset_count, exp_count);
    step();
    step();
    check("ack_holdoff", state, 3);
    expired = 1'b0;
    step();
    step();

    // Saturation after many episodes
    for (int k = 0; k < 256; k++) episode(16'd0, 8'd1, wn, ln);
    check("sat_count", reset_count, 255);
    episode(16'd0, 8'd1, wn, ln);
    check("sat_hold", reset_count, 255);

    // Async reset mid-RESET
    grace_cycles = 16'd0;
    pulse_cycles = 8'd10;
    expired = 1'b1;
    step();
    step();
    step();
    check("mid_reset_srn", sys_reset_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_srn", sys_reset_n, 1);
    check("async_count", reset_count, 0);
    check("async_state", state, 0);
    expired = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
